// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: grants one requester at a time, runs a fixed-latency access, returns done + rdata.
// Optional MEMARB_FIXED_PRI_EN selects fixed lowest-index priority instead of round-robin.
module mem_port_arbiter #(
   parameter int N_REQ   = 2,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ-1:0]    req_we,
   input  logic [N_REQ*AW-1:0] req_addr,
   input  logic [N_REQ*DW-1:0] req_wdata,
   output logic [N_REQ-1:0]    gnt,
   output logic [N_REQ-1:0]    done,
   output logic [DW-1:0]       rdata,
   output logic                busy,
   output logic [AW-1:0]       mem_addr,
   output logic                mem_we,
   output logic [DW-1:0]       mem_wdata,
   input  logic [DW-1:0]       mem_rdata
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_RESP   = 2'd3;

   logic [1:0]    state;
   logic [LW-1:0] lat_cnt;
   logic [PW-1:0] owner;
   logic          acc_we;
   logic [PW-1:0] start_idx;
   logic [PW-1:0] win_idx;
   logic          win_vld;
   logic          last_wait;

`ifdef MEMARB_FIXED_PRI_EN
   assign start_idx = '0;
`else
   logic [PW-1:0] rr_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (state == S_IDLE && win_vld) begin
         rr_ptr <= PW'((int'(win_idx) + 1) % N_REQ);
      end
   end

   assign start_idx = rr_ptr;
`endif

   // Scan downward so the last hit is the first set bit at or after start_idx.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      win_idx = '0;
      win_vld = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[(int'(start_idx) + k) % N_REQ]) begin
            win_idx = PW'((int'(start_idx) + k) % N_REQ);
            win_vld = 1'b1;
         end
      end
   end

   assign last_wait = (lat_cnt == LW'(MEM_LAT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         lat_cnt   <= '0;
         owner     <= '0;
         acc_we    <= 1'b0;
         gnt       <= '0;
         done      <= '0;
         rdata     <= '0;
         busy      <= 1'b0;
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
      end else begin
         // NOTE: pulse outputs default low each cycle; only the state that owns them raises them.
         gnt    <= '0;
         done   <= '0;
         mem_we <= 1'b0;
         case (state)
            S_IDLE: begin
               if (win_vld) begin
                  state        <= S_ACCESS;
                  busy         <= 1'b1;
                  owner        <= win_idx;
                  acc_we       <= req_we[win_idx];
                  mem_we       <= req_we[win_idx];
                  mem_addr     <= req_addr[int'(win_idx)*AW +: AW];
                  mem_wdata    <= req_wdata[int'(win_idx)*DW +: DW];
                  gnt[win_idx] <= 1'b1;
               end
            end
            S_ACCESS: begin
               state   <= S_WAIT;
               lat_cnt <= '0;
            end
            S_WAIT: begin
               if (last_wait) begin
                  state       <= S_RESP;
                  lat_cnt     <= '0;
                  done[owner] <= 1'b1;
                  if (!acc_we) begin
                     rdata <= mem_rdata;
                  end
               end else begin
                  lat_cnt <= lat_cnt + 1'b1;
               end
            end
            S_RESP: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-timeline reference model.
module tb_mem_port_arbiter;

   localparam int N_REQ   = 3;
   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int MEM_LAT = 3;
   localparam int MEM_SZ  = 64;

   logic                clk;
   logic                rst_n;
   logic [N_REQ-1:0]    req;
   logic [N_REQ-1:0]    req_we;
   logic [N_REQ*AW-1:0] req_addr;
   logic [N_REQ*DW-1:0] req_wdata;
   logic [N_REQ-1:0]    gnt;
   logic [N_REQ-1:0]    done;
   logic [DW-1:0]       rdata;
   logic                busy;
   logic [AW-1:0]       mem_addr;
   logic                mem_we;
   logic [DW-1:0]       mem_wdata;
   logic [DW-1:0]       mem_rdata;

   mem_port_arbiter #(.N_REQ(N_REQ), .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory behind the port: combinational read, write on the clock edge.
   logic [DW-1:0] mem [MEM_SZ];
   assign mem_rdata = mem[mem_addr[5:0]];
   always @(posedge clk) if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: when each access is granted and what it must produce.
   logic [DW-1:0] exp_mem [MEM_SZ];
   int            cyc, free_at, g_cyc, own, rr;
   logic          wr;
   logic [AW-1:0] exp_addr;
   logic [DW-1:0] exp_wdata, exp_rdata, pend;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_reset();
      cyc = 0; free_at = 0; g_cyc = -100; own = 0; rr = 0; wr = 1'b0;
      exp_addr = '0; exp_wdata = '0; exp_rdata = '0; pend = '0;
   endtask

   function automatic int pick(input logic [N_REQ-1:0] r, input int start);
      for (int k = 0; k < N_REQ; k++)
         if (r[(start + k) % N_REQ]) return (start + k) % N_REQ;
      return -1;
   endfunction

   // One cycle: check outputs against the model, drive new inputs, let the model decide.
   task automatic step(input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] we,
                       input logic [N_REQ*AW-1:0] a, input logic [N_REQ*DW-1:0] d);
      logic [N_REQ-1:0] e_gnt, e_done;
      int w;
      @(negedge clk);
      if (cyc == g_cyc + MEM_LAT + 1 && !wr) exp_rdata = pend;
      e_gnt  = (cyc == g_cyc) ? N_REQ'(1 << own) : '0;
      e_done = (cyc == g_cyc + MEM_LAT + 1) ? N_REQ'(1 << own) : '0;
      check("gnt", 64'(gnt), 64'(e_gnt));
      check("done", 64'(done), 64'(e_done));
      check("busy", 64'(busy), 64'(cyc >= g_cyc && cyc < g_cyc + MEM_LAT + 2));
      check("mem_we", 64'(mem_we), 64'(cyc == g_cyc && wr));
      check("mem_addr", 64'(mem_addr), 64'(exp_addr));
      check("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
      check("rdata", 64'(rdata), 64'(exp_rdata));
      req = r; req_we = we; req_addr = a; req_wdata = d;
`ifdef MEMARB_FIXED_PRI_EN
      w = pick(r, 0);
`else
      w = pick(r, rr);
`endif
      if (cyc >= free_at && w >= 0) begin
         g_cyc     = cyc + 1;
         free_at   = cyc + MEM_LAT + 3;
         own       = w;
         wr        = we[w];
         exp_addr  = a[w*AW +: AW];
         exp_wdata = d[w*DW +: DW];
         if (wr) exp_mem[exp_addr[5:0]] = exp_wdata;
         else    pend = exp_mem[exp_addr[5:0]];
         rr = (w + 1) % N_REQ;
      end
      cyc++;
   endtask

   function automatic logic [N_REQ*AW-1:0] rnd_addr();
      logic [N_REQ*AW-1:0] v;
      for (int i = 0; i < N_REQ; i++) v[i*AW +: AW] = AW'($urandom_range(0, MEM_SZ - 1));
      return v;
   endfunction

   function automatic logic [N_REQ*DW-1:0] rnd_data();
      logic [N_REQ*DW-1:0] v;
      for (int i = 0; i < N_REQ; i++) v[i*DW +: DW] = DW'($urandom);
      return v;
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, '0, '0, '0);
   endtask

   logic [N_REQ*AW-1:0] a_v;
   logic [N_REQ*DW-1:0] d_v;

   initial begin
      rst_n = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      for (int i = 0; i < MEM_SZ; i++) begin
         mem[i] = DW'($urandom);
         exp_mem[i] = mem[i];
      end
      mem[6'h10] = 32'hDEADBEEF; exp_mem[6'h10] = 32'hDEADBEEF;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_gnt", 64'(gnt), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_mem_we", 64'(mem_we), 64'd0);
      rst_n = 1'b1;

      // Single read of a known word.
      a_v = '0; a_v[0*AW +: AW] = 32'h10;
      step(3'b001, 3'b000, a_v, '0);
      idle(MEM_LAT + 4);
      check("read_deadbeef", 64'(rdata), 64'hDEADBEEF);

      // Write from requester 1; rdata must hold.
      a_v = '0; a_v[1*AW +: AW] = 32'h20;
      d_v = '0; d_v[1*DW +: DW] = 32'h12345678;
      step(3'b010, 3'b010, a_v, d_v);
      idle(MEM_LAT + 4);
      check("write_mem", 64'(mem[6'h20]), 64'h12345678);

      // All requesters held: grants rotate.
      for (int i = 0; i < 4 * (MEM_LAT + 3); i++) step('1, '0, rnd_addr(), rnd_data());
      idle(MEM_LAT + 4);

      // Requester 0 drops its request right after the grant.
      step(3'b001, 3'b000, rnd_addr(), rnd_data());
      idle(MEM_LAT + 4);

      // Randomized traffic.
      for (int i = 0; i < 400; i++)
         step(N_REQ'($urandom_range(0, 7)), N_REQ'($urandom_range(0, 7)), rnd_addr(), rnd_data());
      idle(MEM_LAT + 4);

      // Reset during WAIT of a read: everything clears, no done afterward.
      step(3'b001, 3'b000, rnd_addr(), rnd_data());
      idle(2);
      #1 rst_n = 1'b0;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_gnt", 64'(gnt), 64'd0);
      check("arst_done", 64'(done), 64'd0);
      check("arst_rdata", 64'(rdata), 64'd0);
      check("arst_mem_addr", 64'(mem_addr), 64'd0);
      check("arst_mem_we", 64'(mem_we), 64'd0);
      req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      step(3'b011, 3'b000, rnd_addr(), rnd_data());
      idle(MEM_LAT + 4);
      step(3'b010, 3'b000, rnd_addr(), rnd_data());
      idle(MEM_LAT + 4);
      for (int i = 0; i < 100; i++)
         step(N_REQ'($urandom_range(0, 7)), N_REQ'($urandom_range(0, 7)), rnd_addr(), rnd_data());
      idle(MEM_LAT + 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
